// File: rtl/bdi_pkg.sv
// Shared types and constants for the BDI compressor scheduler.
// Holds encodings, scheduler states and the encoding-to-length map.
package bdi_pkg;

    localparam int LINE_W = 256;

    typedef enum logic [2:0] {
        ENC_B8D1 = 3'd0,
        ENC_B8D2 = 3'd1,
        ENC_B8D4 = 3'd2,
        ENC_B4D1 = 3'd3,
        ENC_B4D2 = 3'd4,
        ENC_B2D1 = 3'd5,
        ENC_ZERO = 3'd6,
        ENC_RAW  = 3'd7
    } bdi_enc_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    function automatic logic [8:0] enc_len(input bdi_enc_e e);
        logic [8:0] l;
        case (e)
            ENC_B8D1: l = 9'd96;
            ENC_B8D2: l = 9'd128;
            ENC_B8D4: l = 9'd192;
            ENC_B4D1: l = 9'd96;
            ENC_B4D2: l = 9'd160;
            ENC_B2D1: l = 9'd144;
            ENC_ZERO: l = 9'd0;
            default:  l = 9'd256;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/bdi_rr_arb2.sv
// Two-input round-robin arbiter.
// On a tie the port that did not win last time is granted.
module bdi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    // Pick the single requester, or alternate on a tie
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner of each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/bdi_compress_scheduler.sv
// Shares one BDI compressor between fill (port 0) and writeback (port 1).
// Optional statistics counters are enabled with BDI_SCHED_STATS_EN.
module bdi_compress_scheduler
    import bdi_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int CU_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [LINE_W-1:0] req0_line,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [LINE_W-1:0] req1_line,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              cu_start,
    output logic [LINE_W-1:0] cu_line,
    input  logic              cu_done,
    input  logic [2:0]        cu_enc,
    input  logic [8:0]        cu_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_src,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [2:0]        rsp_enc,
    output logic [8:0]        rsp_len,
    output logic              rsp_timeout,
    output logic              busy
`ifdef BDI_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_lines,
    output logic [31:0]       stat_saved,
    output logic [15:0]       stat_timeouts
`endif
);

    localparam logic [7:0] TO_LIMIT = 8'(CU_TIMEOUT);

    sched_state_e      state;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic [1:0]        grant;
    logic              idle_ok;
    logic              accept;
    logic [LINE_W-1:0] sel_line;
    logic [TAG_W-1:0]  sel_tag;
    logic [2:0]        cap_enc;
    logic [8:0]        cap_len;

    bdi_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign idle_ok    = (state == S_IDLE) && !rst;
    assign req0_ready = idle_ok && grant[0];
    assign req1_ready = idle_ok && grant[1];
    assign accept     = idle_ok && (grant != 2'b00);
    assign sel_line   = grant[1] ? req1_line : req0_line;
    assign sel_tag    = grant[1] ? req1_tag : req0_tag;
    assign cnt_nxt    = cnt + 8'd1;
    assign busy       = (state != S_IDLE);

    // Sanitise the CU result: ZERO, RAW or oversize lengths become RAW
    always_comb begin
        cap_enc = cu_enc;
        cap_len = cu_len;
        if ((cu_enc == ENC_RAW) || (cu_enc == ENC_ZERO) ||
            (cu_len >= 9'd256)) begin
            cap_enc = ENC_RAW;
            cap_len = enc_len(ENC_RAW);
        end
    end

    // Scheduler FSM with registered CU and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            cu_start    <= 1'b0;
            cu_line     <= '0;
            rsp_valid   <= 1'b0;
            rsp_src     <= 1'b0;
            rsp_tag     <= '0;
            rsp_enc     <= 3'd0;
            rsp_len     <= 9'd0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cu_line     <= sel_line;
                        rsp_tag     <= sel_tag;
                        rsp_src     <= grant[1];
                        rsp_timeout <= 1'b0;
                        if (sel_line == '0) begin
                            rsp_enc   <= ENC_ZERO;
                            rsp_len   <= enc_len(ENC_ZERO);
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            cu_start <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cu_start <= 1'b0;
                    cnt      <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_nxt;
                    if (cu_done) begin
                        rsp_enc   <= cap_enc;
                        rsp_len   <= cap_len;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt_nxt == TO_LIMIT) begin
                        rsp_enc     <= ENC_RAW;
                        rsp_len     <= enc_len(ENC_RAW);
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BDI_SCHED_STATS_EN
    logic        rsp_hs;
    logic [32:0] saved_sum;

    assign rsp_hs    = rsp_valid && rsp_ready;
    assign saved_sum = {1'b0, stat_saved} + 33'(9'd256 - rsp_len);

    // Saturating counters updated on each response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lines    <= 32'd0;
            stat_saved    <= 32'd0;
            stat_timeouts <= 16'd0;
        end else if (rsp_hs) begin
            if (stat_lines != 32'hFFFF_FFFF) begin
                stat_lines <= stat_lines + 32'd1;
            end
            stat_saved <= saved_sum[32] ? 32'hFFFF_FFFF : saved_sum[31:0];
            if (rsp_timeout && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bdi_compress_scheduler.sv
// Self-checking bench for bdi_compress_scheduler.
// Directed steps plus a randomized phase against a transaction-level model.
module tb_bdi_compress_scheduler;

    localparam int TW = 4;
    localparam int TO = 15;

    logic           clk;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [255:0]   req0_line, req1_line;
    logic [TW-1:0]  req0_tag, req1_tag;
    logic           cu_start;
    logic [255:0]   cu_line;
    logic           cu_done;
    logic [2:0]     cu_enc;
    logic [8:0]     cu_len;
    logic           rsp_valid, rsp_ready, rsp_src, rsp_timeout, busy;
    logic [TW-1:0]  rsp_tag;
    logic [2:0]     rsp_enc;
    logic [8:0]     rsp_len;
`ifdef BDI_SCHED_STATS_EN
    logic [31:0]    stat_lines, stat_saved;
    logic [15:0]    stat_timeouts;
    longint         m_lines, m_saved, m_tos;
`endif

    int   compared = 0;
    int   mismatched = 0;
    logic model_last;

    bdi_compress_scheduler #(.TAG_W(TW), .CU_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_line(req0_line), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_line(req1_line), .req1_tag(req1_tag),
        .cu_start(cu_start), .cu_line(cu_line),
        .cu_done(cu_done), .cu_enc(cu_enc), .cu_len(cu_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .rsp_enc(rsp_enc), .rsp_len(rsp_len),
        .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef BDI_SCHED_STATS_EN
        , .stat_lines(stat_lines), .stat_saved(stat_saved),
        .stat_timeouts(stat_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        if (r == '0) r[0] = 1'b1;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {req0_ready, req1_ready, cu_start, rsp_valid,
                  rsp_src, rsp_timeout, busy}, '0);
        chk({tag, "_rsp"}, {rsp_tag, rsp_enc, rsp_len}, '0);
        chk({tag, "_line"}, cu_line, '0);
    endtask

    // One full request/response transaction. Entered and left with
    // the DUT idle, shortly after a rising edge.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [255:0] l0, input logic [255:0] l1,
                           input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                           input int k, input logic [2:0] enc,
                           input logic [8:0] len, input int hold);
        logic [1:0]    g;
        logic          src, zero, xt;
        logic [255:0]  line;
        logic [TW-1:0] tag;
        logic [2:0]    xe;
        logic [8:0]    xl;
        int            exp_cyc, got_cyc;
        req0_valid = v0; req1_valid = v1;
        req0_line = l0; req1_line = l1;
        req0_tag = t0; req1_tag = t1;
        rsp_ready = 1'b0; cu_done = 1'b0;
        #1;
        if (v0 && v1) g = model_last ? 2'b01 : 2'b10;
        else g = {v1, v0};
        chk("req0_ready", 256'(req0_ready), 256'(g[0]));
        chk("req1_ready", 256'(req1_ready), 256'(g[1]));
        src = g[1];
        line = src ? l1 : l0;
        tag = src ? t1 : t0;
        zero = (line == '0);
        model_last = src;
        if (zero) begin
            xe = 3'd6; xl = 9'd0; xt = 1'b0; exp_cyc = 1;
        end else if (k >= 1 && k <= TO) begin
            xt = 1'b0; exp_cyc = 2 + k;
            if (enc >= 3'd6 || len >= 9'd256) begin
                xe = 3'd7; xl = 9'd256;
            end else begin
                xe = enc; xl = len;
            end
        end else begin
            xe = 3'd7; xl = 9'd256; xt = 1'b1; exp_cyc = 2 + TO;
        end
        @(posedge clk); #1;
        got_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            cu_done = !zero && (k >= 1) && (c == 1 + k);
            cu_enc = enc; cu_len = len;
            #1;
            chk("cu_start", 256'(cu_start), 256'(c == 1 && !zero));
            if (c == 1 && !zero) chk("cu_line", cu_line, line);
            if (rsp_valid) begin
                got_cyc = c;
                break;
            end
            chk("inflight", {busy, req0_ready, req1_ready}, 256'(3'b100));
            @(posedge clk); #1;
        end
        cu_done = 1'b0;
        chk("rsp_cycle", 256'(got_cyc), 256'(exp_cyc));
        if (got_cyc == 0) begin
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            model_last = 1'b1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk); #2;
                chk("hold_valid", {rsp_valid, busy, req0_ready, req1_ready},
                    256'(4'b1100));
            end
            chk("rsp_src", 256'(rsp_src), 256'(src));
            chk("rsp_tag", 256'(rsp_tag), 256'(tag));
            chk("rsp_enc", 256'(rsp_enc), 256'(xe));
            chk("rsp_len", 256'(rsp_len), 256'(xl));
            chk("rsp_timeout", 256'(rsp_timeout), 256'(xt));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
`ifdef BDI_SCHED_STATS_EN
        m_lines++; m_saved += 256 - int'(xl); if (xt) m_tos++;
`endif
        #1;
        chk("after_rsp", {rsp_valid, busy}, 256'(2'b00));
        if (v0 && v1) g = model_last ? 2'b01 : 2'b10;
        else g = {v1, v0};
        chk("ready_again", {req0_ready, req1_ready}, 256'({g[0], g[1]}));
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        logic [255:0] la, lb;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_line = '0; req1_line = '0; req0_tag = '0; req1_tag = '0;
        cu_done = 0; cu_enc = 0; cu_len = 0; rsp_ready = 0;
        model_last = 1'b1;
`ifdef BDI_SCHED_STATS_EN
        m_lines = 0; m_saved = 0; m_tos = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(1, 0, rand_line(), '0, 4'h3, 4'h0, 3, 3'd0, 9'd96, 0);

        la = rand_line(); lb = rand_line();
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, la, lb, 4'(2 * i), 4'(2 * i + 1), 2,
                    3'(i + 1), 9'd128, 0);

        run_txn(0, 1, '0, '0, 4'h0, 4'hA, 2, 3'd0, 9'd96, 0);
        run_txn(1, 0, rand_line(), '0, 4'h5, 4'h0, 0, 3'd0, 9'd0, 0);
        run_txn(0, 1, '0, rand_line(), 4'h0, 4'h6, TO, 3'd2, 9'd192, 0);
        run_txn(1, 1, rand_line(), rand_line(), 4'h7, 4'h8, 4,
                3'd5, 9'd144, 10);

        req0_valid = 1; req0_line = rand_line(); req0_tag = 4'h9;
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 256'(busy), 256'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
`ifdef BDI_SCHED_STATS_EN
        m_lines = 0; m_saved = 0; m_tos = 0;
`endif
        chk_all_zero("mid_reset");
        cu_done = 1; cu_enc = 3'd1; cu_len = 9'd128;
        @(posedge clk); #1;
        cu_done = 0;
        chk("stray_done", {busy, rsp_valid, cu_start}, '0);

        run_txn(1, 0, rand_line(), '0, 4'hB, 4'h0, 2, 3'd4, 9'd300, 0);
        run_txn(0, 1, '0, rand_line(), 4'h0, 4'hC, 1, 3'd6, 9'd0, 1);

        for (int n = 0; n < 30; n++) begin
            logic v0, v1;
            logic [255:0] l0, l1;
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            l0 = ($urandom_range(0, 3) == 0) ? '0 : rand_line();
            l1 = ($urandom_range(0, 3) == 0) ? '0 : rand_line();
            run_txn(v0, v1, l0, l1, 4'($urandom), 4'($urandom),
                    int'($urandom_range(0, 20)), 3'($urandom_range(0, 7)),
                    9'($urandom_range(0, 300)), int'($urandom_range(0, 3)));
        end

`ifdef BDI_SCHED_STATS_EN
        chk("stat_lines", 256'(stat_lines), 256'(m_lines));
        chk("stat_saved", 256'(stat_saved), 256'(m_saved));
        chk("stat_timeouts", 256'(stat_timeouts), 256'(m_tos));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
